pry2oht_rra: RTL and testbench
==============================

PRY2OHT_RRA -- requirements
Module: pry2oht_rra

Interface
REQ-001 Parameter WIDTH, default 32, number of requesters, WIDTH >= 1.
REQ-002 Parameter SPLIT, default 2, tree fan-in of the internal priority-to-one-hot trees, SPLIT >= 2.
REQ-003 Parameter DIRECTION, default "LSB": "LSB" rotates priority upward (index i+1 follows i); "MSB" rotates downward (index i-1 follows i).
REQ-004 Parameter IMPLEMENTATION, default 0, passed unchanged to the internal pry2oht_bck instances.
REQ-005 Port clk, input, 1, clock; every register updates on the rising edge.
REQ-006 Port rst, input, 1, reset; synchronous and active-high.
REQ-007 Port req, input, WIDTH, request vector, one bit per requester.
REQ-008 Port lck, input, 1, lock; sampled only at a transfer, it holds the current grant.
REQ-009 Port rdy, input, 1, consumer ready.
REQ-010 Port gnt, output, WIDTH, registered one-hot grant.
REQ-011 Port idx, output, max(1,$clog2(WIDTH)), registered binary index of gnt.
REQ-012 Port vld, output, 1, registered grant valid.

Function
REQ-013 A transfer SHALL occur on any cycle where vld=1 and rdy=1.
REQ-014 The block SHALL have three states: IDLE (vld=0), GRANT (vld=1, unlocked) and LOCK (vld=1, locked).
REQ-015 The arbitration function arb(req, ptr) SHALL proceed as follows:
- Build a masked vector from req, keeping only positions strictly after ptr in the rotation direction.
- If the masked vector is nonzero, return its first set bit found by pry2oht_bck.
- Otherwise, return the first set bit of unmasked req, in DIRECTION order.
REQ-016 ptr SHALL be a one-hot register holding the last transferred grant.
REQ-017 IDLE behaviour:
- If req != 0, register gnt=arb(req, ptr), update idx to match, and move to GRANT.
- Otherwise, stay in IDLE with gnt=0 and idx=0.
REQ-018 Latency from a request in IDLE to vld=1 SHALL be exactly 1 cycle.
REQ-019 In GRANT or LOCK without a transfer, gnt, idx and vld SHALL hold their values, regardless of changes on req or lck.
REQ-020 At a transfer, ptr SHALL load the current gnt.
REQ-021 At a transfer with lck=1, the state SHALL become or stay LOCK, and gnt and idx SHALL be unchanged.
REQ-022 At a transfer with lck=0, the block SHALL re-arbitrate in the same edge:
- If req != 0, load gnt=arb(req, gnt) and go to GRANT.
- If req=0, load gnt=0 and go to IDLE.
- This gives back-to-back grants with no bubble.
REQ-023 In LOCK, a deasserted request bit of the granted requester SHALL NOT release the lock; only a transfer with lck=0 releases it.
REQ-024 gnt SHALL always be one-hot when vld=1 and all-zero when vld=0.
REQ-025 idx SHALL equal the bit position of gnt when vld=1.
REQ-026 With WIDTH=1, the block SHALL grant bit 0 whenever req[0]=1; ptr and masking SHALL degenerate to constants.
REQ-027 A WIDTH that is not a power of SPLIT SHALL be supported, with the padded positions never granted.
REQ-028 Full rotation fairness: with all bits requesting and lck=0, each requester SHALL be granted exactly once in every WIDTH consecutive transfers.

Reset
REQ-029 While rst=1 at a clock edge, the next state SHALL be IDLE, with gnt=0, idx=0 and vld=0.
REQ-030 Reset SHALL set ptr to bit WIDTH-1 for "LSB" and to bit 0 for "MSB", so the first grant after reset favours bit 0 or bit WIDTH-1 respectively.
REQ-031 Reset SHALL override any transfer, lock or request in the same cycle, including a reset asserted mid-grant or in LOCK.

Verification (WIDTH=4, SPLIT=2 unless stated)
REQ-032 Reset, then req=1010 with rdy=0 -> one cycle later gnt=0010, idx=1, vld=1, and these hold while rdy=0.
REQ-033 LSB, req=1111, rdy=1, lck=0 continuously -> gnt sequence 0001, 0010, 0100, 1000, 0001 on consecutive cycles, with vld never dropping.
REQ-034 Backpressure: gnt=0100, rdy=0 for 3 cycles, with req changing to 0001, then 1000, then 0000 -> gnt stays 0100; after the rdy=1 transfer with req=1001, the next gnt=1000.
REQ-035 Lock: transfer of 0100 with lck=1 and req=1111 -> gnt stays 0100 over 2 further transfers with lck=1; the transfer with lck=0 -> next gnt=1000.
REQ-036 Reset mid-operation: rst=1 while in LOCK with gnt=0100 -> next cycle vld=0 and gnt=0000; then req=1111 -> gnt=0001.
REQ-037 DIRECTION="MSB", WIDTH=5 (padded), req=11111, rdy=1 -> gnt sequence 10000, 01000, 00100, 00010, 00001, 10000.

Source files
------------

// File: rtl/pry2oht_rra.sv
//------------------------------------------------------------------------------
// Module   : pry2oht_rra (with helper pry2oht_bck)
// Brief    : Round-robin arbiter with lock, registered one-hot grant and index.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

// Priority-to-one-hot: keeps the lowest set bit; tree of SPLIT-way stages.
module pry2oht_bck #(
    parameter int WIDTH          = 32,
    parameter int SPLIT          = 2,
    parameter int IMPLEMENTATION = 0
) (
    input  logic [WIDTH-1:0] req,
    output logic [WIDTH-1:0] gnt,
    output logic             vld
);
    generate
        if (IMPLEMENTATION != 0 || WIDTH <= SPLIT) begin : g_flat
            assign gnt = req & (~req + WIDTH'(1));
            assign vld = |req;
        end else begin : g_tree
            localparam int CH = (WIDTH + SPLIT - 1) / SPLIT;
            localparam int PW = CH * SPLIT;
            logic [PW-1:0]    w_pad;
            logic [PW-1:0]    w_sub;
            logic [PW-1:0]    w_gated;
            logic [SPLIT-1:0] w_any;
            logic [SPLIT-1:0] w_sel;

            // Padded positions are tied low so they can never win.
            assign w_pad = PW'(req);
            for (genvar k = 0; k < SPLIT; k++) begin : g_chunk
                pry2oht_bck #(
                    .WIDTH          (CH),
                    .SPLIT          (SPLIT),
                    .IMPLEMENTATION (IMPLEMENTATION)
                ) u_sub (
                    .req (w_pad[k*CH +: CH]),
                    .gnt (w_sub[k*CH +: CH]),
                    .vld (w_any[k])
                );
                assign w_gated[k*CH +: CH] = w_sub[k*CH +: CH] & {CH{w_sel[k]}};
            end
            assign w_sel = w_any & (~w_any + SPLIT'(1));
            assign gnt   = w_gated[WIDTH-1:0];
            assign vld   = |w_gated;
        end
    endgenerate
endmodule

module pry2oht_rra #(
    parameter int WIDTH          = 32,
    parameter int SPLIT          = 2,
    parameter     DIRECTION      = "LSB",
    parameter int IMPLEMENTATION = 0
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [WIDTH-1:0]                     req,
    input  logic                                 lck,
    input  logic                                 rdy,
    output logic [WIDTH-1:0]                     gnt,
    output logic [((WIDTH > 1) ? $clog2(WIDTH) : 1)-1:0] idx,
    output logic                                 vld
);
    localparam int              IW        = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam bit              c_MSB     = (DIRECTION == "MSB");
    localparam logic [WIDTH-1:0] c_ONE     = WIDTH'(1);
    localparam logic [WIDTH-1:0] c_PTR_RST = c_MSB ? c_ONE : (c_ONE << (WIDTH - 1));

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_LOCK  = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_gnt;
    logic [WIDTH-1:0] r_ptr;
    logic [IW-1:0]    r_idx;
    logic             r_vld;

    function automatic logic [WIDTH-1:0] f_rev(input logic [WIDTH-1:0] v);
        f_rev = '0;
        for (int i = 0; i < WIDTH; i++) f_rev[i] = v[WIDTH-1-i];
    endfunction

    function automatic logic [IW-1:0] f_enc(input logic [WIDTH-1:0] v);
        f_enc = '0;
        for (int i = 0; i < WIDTH; i++) if (v[i]) f_enc = f_enc | IW'(i);
    endfunction

    // Arbitration runs in an LSB-ordered domain; MSB mode mirrors in and out.
    logic [WIDTH-1:0] w_base, w_rreq, w_rbase, w_mask, w_gm, w_gu, w_rarb, w_arb;
    logic             w_msk_any, w_req_any;
    logic [IW-1:0]    w_arb_idx;

    assign w_base  = r_vld ? r_gnt : r_ptr;
    assign w_rreq  = c_MSB ? f_rev(req) : req;
    assign w_rbase = c_MSB ? f_rev(w_base) : w_base;
    assign w_mask  = w_rreq & ~(w_rbase | (w_rbase - c_ONE));

    pry2oht_bck #(.WIDTH(WIDTH), .SPLIT(SPLIT), .IMPLEMENTATION(IMPLEMENTATION)) u_msk (
        .req (w_mask), .gnt (w_gm), .vld (w_msk_any)
    );
    pry2oht_bck #(.WIDTH(WIDTH), .SPLIT(SPLIT), .IMPLEMENTATION(IMPLEMENTATION)) u_all (
        .req (w_rreq), .gnt (w_gu), .vld (w_req_any)
    );

    assign w_rarb    = w_msk_any ? w_gm : w_gu;
    assign w_arb     = c_MSB ? f_rev(w_rarb) : w_rarb;
    assign w_arb_idx = f_enc(w_arb);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_gnt   <= '0;
            r_idx   <= '0;
            r_vld   <= 1'b0;
            r_ptr   <= c_PTR_RST;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req_any) begin
                        r_gnt   <= w_arb;
                        r_idx   <= w_arb_idx;
                        r_vld   <= 1'b1;
                        r_state <= S_GRANT;
                    end else begin
                        r_gnt <= '0;
                        r_idx <= '0;
                        r_vld <= 1'b0;
                    end
                end
                S_GRANT, S_LOCK: begin
                    if (rdy) begin
                        r_ptr <= r_gnt;
                        if (lck) begin
                            r_state <= S_LOCK;
                        end else if (w_req_any) begin
                            r_gnt   <= w_arb;
                            r_idx   <= w_arb_idx;
                            r_state <= S_GRANT;
                        end else begin
                            r_gnt   <= '0;
                            r_idx   <= '0;
                            r_vld   <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_gnt   <= '0;
                    r_idx   <= '0;
                    r_vld   <= 1'b0;
                end
            endcase
        end
    end

    assign gnt = r_gnt;
    assign idx = r_idx;
    assign vld = r_vld;
endmodule

`default_nettype wire

// File: tb/tb_pry2oht_rra.sv
//------------------------------------------------------------------------------
// Module   : tb_pry2oht_rra
// Brief    : Directed bench for pry2oht_rra (4-bit LSB, 5-bit MSB, 1-bit).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_pry2oht_rra;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req_a = '0;
    logic       lck_a = 1'b0, rdy_a = 1'b0;
    logic [3:0] gnt_a;
    logic [1:0] idx_a;
    logic       vld_a;
    logic [4:0] req_b = '0;
    logic       lck_b = 1'b0, rdy_b = 1'b0;
    logic [4:0] gnt_b;
    logic [2:0] idx_b;
    logic       vld_b;
    logic [0:0] req_c = '0;
    logic       lck_c = 1'b0, rdy_c = 1'b0;
    logic [0:0] gnt_c;
    logic [0:0] idx_c;
    logic       vld_c;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pry2oht_rra #(.WIDTH(4), .SPLIT(2), .DIRECTION("LSB"), .IMPLEMENTATION(0)) u_a (
        .clk(clk), .rst(rst), .req(req_a), .lck(lck_a), .rdy(rdy_a),
        .gnt(gnt_a), .idx(idx_a), .vld(vld_a)
    );
    pry2oht_rra #(.WIDTH(5), .SPLIT(2), .DIRECTION("MSB"), .IMPLEMENTATION(0)) u_b (
        .clk(clk), .rst(rst), .req(req_b), .lck(lck_b), .rdy(rdy_b),
        .gnt(gnt_b), .idx(idx_b), .vld(vld_b)
    );
    pry2oht_rra #(.WIDTH(1), .SPLIT(2), .DIRECTION("LSB"), .IMPLEMENTATION(0)) u_c (
        .clk(clk), .rst(rst), .req(req_c), .lck(lck_c), .rdy(rdy_c),
        .gnt(gnt_c), .idx(idx_c), .vld(vld_c)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input string tag, input logic [3:0] eg, input logic [1:0] ei, input logic ev);
        n_assert++;
        assert ({gnt_a, idx_a, vld_a} === {eg, ei, ev}) else begin
            n_fail++;
            $error("FAIL %s: gnt/idx/vld = %b/%0d/%b, expected %b/%0d/%b",
                   tag, gnt_a, idx_a, vld_a, eg, ei, ev);
        end
    endtask

    task automatic chk_b(input string tag, input logic [4:0] eg, input logic [2:0] ei, input logic ev);
        n_assert++;
        assert ({gnt_b, idx_b, vld_b} === {eg, ei, ev}) else begin
            n_fail++;
            $error("FAIL %s: gnt/idx/vld = %b/%0d/%b, expected %b/%0d/%b",
                   tag, gnt_b, idx_b, vld_b, eg, ei, ev);
        end
    endtask

    task automatic chk_c(input string tag, input logic eg, input logic ev);
        n_assert++;
        assert ({gnt_c, idx_c, vld_c} === {eg, 1'b0, ev}) else begin
            n_fail++;
            $error("FAIL %s: gnt/idx/vld = %b/%0d/%b, expected %b/0/%b",
                   tag, gnt_c, idx_c, vld_c, eg, ev);
        end
    endtask

    initial begin
        // Reset state
        tick(); tick();
        chk_a("rst_a", 4'b0000, 2'd0, 1'b0);
        chk_b("rst_b", 5'b00000, 3'd0, 1'b0);
        chk_c("rst_c", 1'b0, 1'b0);
        rst = 1'b0;

        // First grant with rdy low, then hold under changing req
        req_a = 4'b1010; rdy_a = 1'b0;
        tick(); chk_a("first_grant", 4'b0010, 2'd1, 1'b1);
        req_a = 4'b0101;
        tick(); chk_a("hold_rdy0_1", 4'b0010, 2'd1, 1'b1);
        tick(); chk_a("hold_rdy0_2", 4'b0010, 2'd1, 1'b1);
        rdy_a = 1'b1; req_a = 4'b1111;
        tick(); chk_a("rearb_after_0010", 4'b0100, 2'd2, 1'b1);

        // Backpressure with req churning
        rdy_a = 1'b0; req_a = 4'b0001;
        tick(); chk_a("bp_1", 4'b0100, 2'd2, 1'b1);
        req_a = 4'b1000;
        tick(); chk_a("bp_2", 4'b0100, 2'd2, 1'b1);
        req_a = 4'b0000;
        tick(); chk_a("bp_3", 4'b0100, 2'd2, 1'b1);
        rdy_a = 1'b1; req_a = 4'b1001;
        tick(); chk_a("bp_release", 4'b1000, 2'd3, 1'b1);
        rdy_a = 1'b0; req_a = 4'b0000;
        tick(); chk_a("bp_hold_req0", 4'b1000, 2'd3, 1'b1);

        // Full rotation, back-to-back
        rdy_a = 1'b1; req_a = 4'b1111;
        tick(); chk_a("rot_0", 4'b0001, 2'd0, 1'b1);
        tick(); chk_a("rot_1", 4'b0010, 2'd1, 1'b1);
        tick(); chk_a("rot_2", 4'b0100, 2'd2, 1'b1);
        tick(); chk_a("rot_3", 4'b1000, 2'd3, 1'b1);
        tick(); chk_a("rot_4", 4'b0001, 2'd0, 1'b1);
        tick(); chk_a("rot_5", 4'b0010, 2'd1, 1'b1);
        tick(); chk_a("rot_6", 4'b0100, 2'd2, 1'b1);

        // Lock on 0100, including a dropped request bit while locked
        lck_a = 1'b1;
        tick(); chk_a("lock_0", 4'b0100, 2'd2, 1'b1);
        tick(); chk_a("lock_1", 4'b0100, 2'd2, 1'b1);
        tick(); chk_a("lock_2", 4'b0100, 2'd2, 1'b1);
        req_a = 4'b1011;
        tick(); chk_a("lock_req_drop", 4'b0100, 2'd2, 1'b1);
        lck_a = 1'b0; req_a = 4'b1111;
        tick(); chk_a("unlock", 4'b1000, 2'd3, 1'b1);

        // Reset while locked on 0100
        tick(); chk_a("pre_rst_0", 4'b0001, 2'd0, 1'b1);
        tick(); chk_a("pre_rst_1", 4'b0010, 2'd1, 1'b1);
        tick(); chk_a("pre_rst_2", 4'b0100, 2'd2, 1'b1);
        lck_a = 1'b1;
        tick(); chk_a("pre_rst_lock", 4'b0100, 2'd2, 1'b1);
        rst = 1'b1;
        tick(); chk_a("rst_in_lock", 4'b0000, 2'd0, 1'b0);
        rst = 1'b0; lck_a = 1'b0; rdy_a = 1'b0;
        tick(); chk_a("post_rst_grant", 4'b0001, 2'd0, 1'b1);

        // Transfer with no requests returns to idle; pointer remembers 0001
        rdy_a = 1'b1; req_a = 4'b0000;
        tick(); chk_a("to_idle", 4'b0000, 2'd0, 1'b0);
        tick(); chk_a("stay_idle", 4'b0000, 2'd0, 1'b0);
        req_a = 4'b0101;
        tick(); chk_a("idle_ptr_mask", 4'b0100, 2'd2, 1'b1);

        // MSB direction, padded width 5
        req_b = 5'b11111; rdy_b = 1'b1;
        tick(); chk_b("msb_0", 5'b10000, 3'd4, 1'b1);
        tick(); chk_b("msb_1", 5'b01000, 3'd3, 1'b1);
        tick(); chk_b("msb_2", 5'b00100, 3'd2, 1'b1);
        tick(); chk_b("msb_3", 5'b00010, 3'd1, 1'b1);
        tick(); chk_b("msb_4", 5'b00001, 3'd0, 1'b1);
        tick(); chk_b("msb_5", 5'b10000, 3'd4, 1'b1);

        // Single requester
        req_c = 1'b1; rdy_c = 1'b1;
        tick(); chk_c("w1_grant", 1'b1, 1'b1);
        tick(); chk_c("w1_regrant", 1'b1, 1'b1);
        req_c = 1'b0;
        tick(); chk_c("w1_idle", 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
